// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_pkg
// Purpose  : Shared constants, FSM state type and peg helper for the scorer.
// Revision : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    localparam int N_PEGS = 4;
    localparam int PEG_W  = 4;
    localparam int CODE_W = N_PEGS * PEG_W;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXACT   = 2'd1,
        ST_PARTIAL = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    function automatic logic [PEG_W-1:0] get_peg(input logic [CODE_W-1:0] word,
                                                 input logic [IDX_W-1:0]  k);
        get_peg = word[int'(k)*PEG_W +: PEG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mastermind_scorer_peg_bank.sv
`default_nettype none
// ============================================================================
// Module   : mm_peg_bank
// Purpose  : Loadable 16-bit code snapshot with a single peg read port.
// Revision : 1.0 - initial release
// ============================================================================
module mm_peg_bank
    import mastermind_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD,
    input  logic [CODE_W-1:0] D,
    input  logic [IDX_W-1:0]  SEL,
    output logic [PEG_W-1:0]  PEG
);

    logic [CODE_W-1:0] bank_q;
    logic [CODE_W-1:0] bank_d;

    always_comb begin
        bank_d = bank_q;
        if (LOAD) begin
            bank_d = D;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign PEG = get_peg(bank_q, SEL);

endmodule
`default_nettype wire

// File: rtl/mastermind_scorer.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_scorer
// Purpose  : Multi-cycle black/white scoring with attempt and win/lose tracking.
// Revision : 1.0 - initial release
// ============================================================================
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int MAX_TRIES = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              NEW_GAME,
    input  logic [CODE_W-1:0] SECRET,
    input  logic [CODE_W-1:0] GUESS,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  BLACK,
    output logic [CNT_W-1:0]  WHITE,
    output logic [3:0]        TRIES,
    output logic              WIN,
    output logic              LOSE
);

    localparam logic [3:0]       c_max_tries = 4'(MAX_TRIES);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(N_PEGS - 1);
    localparam logic [CNT_W-1:0] c_all_black = CNT_W'(N_PEGS);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_i_q, idx_i_d;
    logic [IDX_W-1:0]    idx_j_q, idx_j_d;
    logic [N_PEGS-1:0]   gused_q, gused_d;
    logic [N_PEGS-1:0]   sused_q, sused_d;
    logic [CNT_W-1:0]    black_cnt_q, black_cnt_d;
    logic [CNT_W-1:0]    white_cnt_q, white_cnt_d;
    logic [CNT_W-1:0]    black_q, black_d;
    logic [CNT_W-1:0]    white_q, white_d;
    logic [3:0]          tries_q, tries_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;
    logic                done_q, done_d;

    logic                w_load;
    logic [IDX_W-1:0]    w_s_sel;
    logic [PEG_W-1:0]    w_g_peg;
    logic [PEG_W-1:0]    w_s_peg;
    logic                w_peg_eq;

    // EXACT compares g[i] with s[i]; PARTIAL compares g[i] with s[j].
    assign w_s_sel  = (state_q == ST_EXACT) ? idx_i_q : idx_j_q;
    assign w_peg_eq = (w_g_peg == w_s_peg);

    mm_peg_bank u_guess_bank (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (w_load),
        .D     (GUESS),
        .SEL   (idx_i_q),
        .PEG   (w_g_peg)
    );

    mm_peg_bank u_secret_bank (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (w_load),
        .D     (SECRET),
        .SEL   (w_s_sel),
        .PEG   (w_s_peg)
    );

    always_comb begin
        state_d     = state_q;
        idx_i_d     = idx_i_q;
        idx_j_d     = idx_j_q;
        gused_d     = gused_q;
        sused_d     = sused_q;
        black_cnt_d = black_cnt_q;
        white_cnt_d = white_cnt_q;
        black_d     = black_q;
        white_d     = white_q;
        tries_d     = tries_q;
        win_d       = win_q;
        lose_d      = lose_q;
        done_d      = 1'b0;
        w_load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (NEW_GAME) begin
                    tries_d = '0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    black_d = '0;
                    white_d = '0;
                end else if (START && !win_q && !lose_q) begin
                    w_load      = 1'b1;
                    idx_i_d     = '0;
                    idx_j_d     = '0;
                    gused_d     = '0;
                    sused_d     = '0;
                    black_cnt_d = '0;
                    white_cnt_d = '0;
                    state_d     = ST_EXACT;
                end
            end
            ST_EXACT: begin
                if (w_peg_eq) begin
                    black_cnt_d       = black_cnt_q + 1'b1;
                    gused_d[idx_i_q]  = 1'b1;
                    sused_d[idx_i_q]  = 1'b1;
                end
                idx_i_d = idx_i_q + 1'b1;
                if (idx_i_q == c_last_idx) begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (!gused_q[idx_i_q] && !sused_q[idx_j_q] && w_peg_eq) begin
                    white_cnt_d      = white_cnt_q + 1'b1;
                    gused_d[idx_i_q] = 1'b1;
                    sused_d[idx_j_q] = 1'b1;
                end
                idx_j_d = idx_j_q + 1'b1;
                if (idx_j_q == c_last_idx) begin
                    idx_i_d = idx_i_q + 1'b1;
                    if (idx_i_q == c_last_idx) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                black_d = black_cnt_q;
                white_d = white_cnt_q;
                tries_d = tries_q + 4'd1;
                done_d  = 1'b1;
                if (black_cnt_q == c_all_black) begin
                    win_d = 1'b1;
                end else if (tries_q + 4'd1 == c_max_tries) begin
                    lose_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            idx_i_q     <= '0;
            idx_j_q     <= '0;
            gused_q     <= '0;
            sused_q     <= '0;
            black_cnt_q <= '0;
            white_cnt_q <= '0;
            black_q     <= '0;
            white_q     <= '0;
            tries_q     <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_i_q     <= idx_i_d;
            idx_j_q     <= idx_j_d;
            gused_q     <= gused_d;
            sused_q     <= sused_d;
            black_cnt_q <= black_cnt_d;
            white_cnt_q <= white_cnt_d;
            black_q     <= black_d;
            white_q     <= white_d;
            tries_q     <= tries_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            done_q      <= done_d;
        end
    end

    // The DONE cycle still counts as busy so the window spans 22 cycles.
    assign BUSY  = (state_q != ST_IDLE) || done_q;
    assign DONE  = done_q;
    assign BLACK = black_q;
    assign WHITE = white_q;
    assign TRIES = tries_q;
    assign WIN   = win_q;
    assign LOSE  = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mastermind_scorer
// Purpose  : Scoreboard bench for mastermind_scorer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mastermind_scorer;

    localparam int MAXT = 10;

    typedef struct {
        int black;
        int white;
        int tries;
        int win;
        int lose;
        int cyc;
    } exp_t;

    logic        CLK      = 1'b0;
    logic        RESET    = 1'b0;
    logic        START    = 1'b0;
    logic        NEW_GAME = 1'b0;
    logic [15:0] SECRET   = '0;
    logic [15:0] GUESS    = '0;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  BLACK;
    logic [2:0]  WHITE;
    logic [3:0]  TRIES;
    logic        WIN;
    logic        LOSE;

    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   m_tries = 0;
    int   m_win   = 0;
    int   m_lose  = 0;
    exp_t sb[$];
    exp_t mon_e;

    mastermind_scorer #(.MAX_TRIES(MAXT)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .NEW_GAME (NEW_GAME),
        .SECRET   (SECRET),
        .GUESS    (GUESS),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .BLACK    (BLACK),
        .WHITE    (WHITE),
        .TRIES    (TRIES),
        .WIN      (WIN),
        .LOSE     (LOSE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Colour-histogram reference: white = sum of min counts minus exact hits.
    task automatic score(input logic [15:0] s, input logic [15:0] g,
                         output int b, output int w);
        int cs[16];
        int cg[16];
        int tot;
        logic [3:0] sp, gp;
        for (int c = 0; c < 16; c++) begin
            cs[c] = 0;
            cg[c] = 0;
        end
        b = 0;
        for (int k = 0; k < 4; k++) begin
            sp = s[4*k +: 4];
            gp = g[4*k +: 4];
            if (sp == gp) b++;
            cs[sp]++;
            cg[gp]++;
        end
        tot = 0;
        for (int c = 0; c < 16; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
        w = tot - b;
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_latency", cyc - mon_e.cyc, 21);
                chk("busy_at_done", int'(BUSY), 1);
                chk("black", int'(BLACK), mon_e.black);
                chk("white", int'(WHITE), mon_e.white);
                chk("tries", int'(TRIES), mon_e.tries);
                chk("win",   int'(WIN),   mon_e.win);
                chk("lose",  int'(LOSE),  mon_e.lose);
            end
        end
    end

    task automatic do_guess(input logic [15:0] s, input logic [15:0] g, input bit perturb);
        int   b, w;
        bit   acc;
        exp_t e;
        @(posedge CLK); #1;
        SECRET = s;
        GUESS  = g;
        START  = 1'b1;
        acc = (m_win == 0) && (m_lose == 0);
        @(posedge CLK); #1;
        START = 1'b0;
        if (acc) begin
            score(s, g, b, w);
            m_tries++;
            if (b == 4) m_win = 1;
            else if (m_tries == MAXT) m_lose = 1;
            e = '{b, w, m_tries, m_win, m_lose, cyc};
            sb.push_back(e);
            if (perturb) GUESS = ~g;
        end
        @(negedge CLK);
        chk("busy_after_start", int'(BUSY), int'(acc));
        if (perturb) begin
            @(posedge CLK); #1 NEW_GAME = 1'b1;
            @(posedge CLK); #1 NEW_GAME = 1'b0;
        end
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge CLK);
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic new_game();
        @(posedge CLK); #1 NEW_GAME = 1'b1;
        @(posedge CLK); #1 NEW_GAME = 1'b0;
        m_tries = 0;
        m_win   = 0;
        m_lose  = 0;
        chk("ng_tries", int'(TRIES), 0);
        chk("ng_win",   int'(WIN),   0);
        chk("ng_lose",  int'(LOSE),  0);
        chk("ng_black", int'(BLACK), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  int'(BUSY),  0);
        chk({tag, "_done"},  int'(DONE),  0);
        chk({tag, "_black"}, int'(BLACK), 0);
        chk({tag, "_white"}, int'(WHITE), 0);
        chk({tag, "_tries"}, int'(TRIES), 0);
        chk({tag, "_win"},   int'(WIN),   0);
        chk({tag, "_lose"},  int'(LOSE),  0);
    endtask

    initial begin
        logic [15:0] lg;

        #2 RESET = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;

        // Abort a scoring run partway through PARTIAL.
        @(posedge CLK); #1;
        SECRET = 16'h4321;
        GUESS  = 16'h1234;
        START  = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        repeat (10) @(posedge CLK);
        #3 RESET = 1'b1;
        #1 chk_all_zero("mid_reset");
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;
        repeat (25) @(posedge CLK);

        do_guess(16'h4321, 16'h4321, 1'b0);
        do_guess(16'h4321, 16'h1234, 1'b0);
        @(negedge CLK);
        chk("win_hold_tries", int'(TRIES), 1);

        new_game();
        do_guess(16'h4321, 16'h1234, 1'b0);
        do_guess(16'h2211, 16'h3121, 1'b0);
        do_guess(16'h1111, 16'h2221, 1'b0);

        new_game();
        for (int n = 0; n < MAXT; n++) begin
            lg = 16'($urandom);
            if (lg == 16'h5678) lg = 16'h5679;
            do_guess(16'h5678, lg, 1'b0);
        end
        do_guess(16'h5678, 16'h5678, 1'b0);
        @(negedge CLK);
        chk("lose_hold_tries", int'(TRIES), MAXT);

        // NEW_GAME and START together: clear only, no scoring.
        @(posedge CLK); #1;
        NEW_GAME = 1'b1;
        START    = 1'b1;
        @(posedge CLK); #1;
        NEW_GAME = 1'b0;
        START    = 1'b0;
        m_tries = 0;
        m_win   = 0;
        m_lose  = 0;
        @(negedge CLK);
        chk("ngs_busy",  int'(BUSY),  0);
        chk("ngs_tries", int'(TRIES), 0);
        chk("ngs_lose",  int'(LOSE),  0);
        repeat (25) @(posedge CLK);

        do_guess(16'h8765, 16'h5878, 1'b0);
        do_guess(16'h9abc, 16'hc9a1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
